// File: rtl/lfsr_prng_stream.sv
// XNOR-Fibonacci LFSR random source with run-time reseed, post-(re)seed warm-up
// and a valid/ready output stream; each accepted word advances the LFSR OUT_W steps.

module lfsr_prng_stream #(
    parameter int                LFSR_W   = 64,
    parameter int                OUT_W    = 3,
    parameter logic [LFSR_W-1:0] TAPS     = 64'hD800_0000_0000_0000,
    parameter logic [LFSR_W-1:0] SEED_RST = '0,
    parameter int                WARMUP   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_valid_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic              seed_ready_o,
    output logic              rnd_valid_o,
    input  logic              rnd_ready_i,
    output logic [OUT_W-1:0]  rnd_o,
    output logic              seed_fixed_o
);

    if (OUT_W > LFSR_W || LFSR_W < 2 || OUT_W < 1) begin : g_bad_params
        $error("lfsr_prng_stream: illegal LFSR_W/OUT_W combination");
    end

    // A zero-width counter is not legal, so WARMUP==0 still gets one bit.
    localparam int WCNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WARMUP);

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    localparam state_t RST_STATE = (WARMUP > 0) ? ST_WARMUP : ST_RUN;

    function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] v;
        v = s;
        for (int i = 0; i < OUT_W; i++) begin
            v = {v[LFSR_W-2:0], ~^(v & TAPS)};
        end
        return v;
    endfunction

    state_t             state_q, state_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               seed_fixed_q, seed_fixed_d;

    logic               run_s;
    logic               reseed_s;
    logic [LFSR_W-1:0]  adv_s;
    logic [LFSR_W-1:0]  seed_load_s;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RST_STATE;
            lfsr_q       <= SEED_RST;
            wcnt_q       <= WCNT_INIT;
            seed_fixed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            wcnt_q       <= wcnt_d;
            seed_fixed_q <= seed_fixed_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WARMUP: begin
                if (wcnt_q == WCNT_W'(1)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WARMUP;
                end
            end
            ST_RUN: begin
                if (reseed_s) begin
                    state_d = RST_STATE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    // Datapath: an all-ones seed would lock the XNOR LFSR, so bit 0 is cleared.
    always_comb begin
        run_s       = (state_q == ST_RUN);
        reseed_s    = run_s & seed_valid_i;
        adv_s       = lfsr_advance(lfsr_q);
        seed_load_s = seed_i;
        if (&seed_i) begin
            seed_load_s[0] = 1'b0;
        end else begin
            seed_load_s[0] = seed_i[0];
        end

        lfsr_d       = lfsr_q;
        wcnt_d       = wcnt_q;
        seed_fixed_d = 1'b0;
        case (state_q)
            ST_WARMUP: begin
                lfsr_d = adv_s;
                wcnt_d = wcnt_q - WCNT_W'(1);
            end
            ST_RUN: begin
                if (reseed_s) begin
                    lfsr_d       = seed_load_s;
                    wcnt_d       = WCNT_INIT;
                    seed_fixed_d = &seed_i;
                end else if (rnd_ready_i) begin
                    lfsr_d = adv_s;
                end else begin
                    lfsr_d = lfsr_q;
                end
            end
            default: begin
                lfsr_d = SEED_RST;
                wcnt_d = WCNT_INIT;
            end
        endcase
    end

    // Output decode, straight from registers.
    always_comb begin
        rnd_valid_o  = 1'b0;
        seed_ready_o = 1'b0;
        case (state_q)
            ST_RUN: begin
                rnd_valid_o  = 1'b1;
                seed_ready_o = 1'b1;
            end
            ST_WARMUP: begin
                rnd_valid_o  = 1'b0;
                seed_ready_o = 1'b0;
            end
            default: begin
                rnd_valid_o  = 1'b0;
                seed_ready_o = 1'b0;
            end
        endcase
        rnd_o        = lfsr_q[OUT_W-1:0];
        seed_fixed_o = seed_fixed_q;
    end

    lfsr_prng_stream_chk #(
        .LFSR_W (LFSR_W)
    ) u_chk (
        .clk    (clk),
        .rst    (rst),
        .lfsr_i (lfsr_q)
    );

endmodule

// Checker: the LFSR state must never reach the all-ones lock-up value.
module lfsr_prng_stream_chk #(
    parameter int LFSR_W = 64
) (
    input logic              clk,
    input logic              rst,
    input logic [LFSR_W-1:0] lfsr_i
);

    a_no_lockup: assert property (@(posedge clk) disable iff (rst) !(&lfsr_i));

endmodule
